// File: rtl/digit_pkg.sv
// Shared types and constants for the digit classifier output stage.
package digit_pkg;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int SCORE_W_DEF     = 16;
  localparam int IDX_W           = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/digit_stability_filter.sv
// Emits a candidate winner only once it has won STABLE_FRAMES consecutive good frames;
// the same digit is not re-emitted until a different winner breaks the run.
module digit_stability_filter
  import digit_pkg::*;
#(
  parameter int SCORE_W       = SCORE_W_DEF,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cand_valid,
  input  logic [IDX_W-1:0]          cand_idx,
  input  logic signed [SCORE_W-1:0] cand_score,
  output logic                      emit_valid,
  output logic [IDX_W-1:0]          emit_idx,
  output logic signed [SCORE_W-1:0] emit_score
);

  localparam logic [3:0] RUN_MAX = 4'(STABLE_FRAMES);

  logic [3:0]       run_reg, run_next;
  logic [IDX_W-1:0] prev_idx_reg, prev_idx_next;
  logic             same_winner;

  // A zero run means no good frame has been seen since reset, so nothing to agree with.
  assign same_winner = (run_reg != 4'd0) && (cand_idx == prev_idx_reg);

  always_comb begin
    run_next      = run_reg;
    prev_idx_next = prev_idx_reg;
    emit_valid    = 1'b0;
    if (cand_valid) begin
      prev_idx_next = cand_idx;
      if (same_winner) begin
        if (run_reg < RUN_MAX) begin
          run_next   = run_reg + 4'd1;
          emit_valid = ((run_reg + 4'd1) == RUN_MAX);
        end
      end else begin
        run_next   = 4'd1;
        emit_valid = (RUN_MAX == 4'd1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg      <= 4'd0;
      prev_idx_reg <= '0;
    end else begin
      run_reg      <= run_next;
      prev_idx_reg <= prev_idx_next;
    end
  end

  assign emit_idx   = cand_idx;
  assign emit_score = cand_score;

endmodule

// File: rtl/digit_argmax.sv
// Serial signed arg-max over one frame of class scores with frame-length checking.
// Optional DIGIT_ARGMAX_STABLE_EN gates results through digit_stability_filter.
module digit_argmax
  import digit_pkg::*;
#(
  parameter int SCORE_W       = SCORE_W_DEF,
  parameter int NUM_CLASSES   = NUM_CLASSES_DEF,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [SCORE_W-1:0] score_in,
  input  logic                      score_valid,
  input  logic                      score_last,
  output logic                      valid_out,
  output logic [IDX_W-1:0]          decision,
  output logic signed [SCORE_W-1:0] max_score,
  output logic                      frame_err,
  output logic                      busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  if (NUM_CLASSES < 2 || NUM_CLASSES > 16) begin : g_bad_num_classes
    $error("digit_argmax: NUM_CLASSES must be in 2..16");
  end
  if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15) begin : g_bad_stable_frames
    $error("digit_argmax: STABLE_FRAMES must be in 1..15");
  end

  argmax_state_t             state_reg, state_next;
  logic [IDX_W-1:0]          idx_reg, idx_next;
  logic [IDX_W-1:0]          best_idx_reg, best_idx_next;
  logic signed [SCORE_W-1:0] best_reg, best_next;
  logic                      score_gt;
  logic                      err_next;

  logic                      cand_valid;
  logic [IDX_W-1:0]          cand_idx;
  logic signed [SCORE_W-1:0] cand_score;
  logic                      emit_valid;
  logic [IDX_W-1:0]          emit_idx;
  logic signed [SCORE_W-1:0] emit_score;

  logic                      valid_out_reg;
  logic                      frame_err_reg;
  logic [IDX_W-1:0]          decision_reg;
  logic signed [SCORE_W-1:0] max_score_reg;

  // Strict compare keeps the earlier index on ties.
  assign score_gt = (score_in > best_reg);

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    best_next     = best_reg;
    best_idx_next = best_idx_reg;
    err_next      = 1'b0;
    cand_valid    = 1'b0;
    cand_idx      = best_idx_reg;
    cand_score    = best_reg;
    case (state_reg)
      IDLE: begin
        if (score_valid) begin
          best_next     = score_in;
          best_idx_next = '0;
          idx_next      = IDX_W'(1);
          if (score_last) err_next = 1'b1;
          else            state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (score_valid) begin
          if (score_gt) begin
            best_next     = score_in;
            best_idx_next = idx_reg;
          end
          idx_next = idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) begin
            if (score_last) begin
              // The final beat's own compare is folded in before handing off.
              cand_valid = 1'b1;
              cand_idx   = score_gt ? idx_reg : best_idx_reg;
              cand_score = score_gt ? score_in : best_reg;
              state_next = IDLE;
            end else begin
              err_next   = 1'b1;
              state_next = DISCARD;
            end
          end else if (score_last) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DISCARD: begin
        if (score_valid && score_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      best_idx_reg <= '0;
      best_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      best_idx_reg <= best_idx_next;
      best_reg     <= best_next;
    end
  end

`ifdef DIGIT_ARGMAX_STABLE_EN
  digit_stability_filter #(
    .SCORE_W       (SCORE_W),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_stability (
    .clk        (clk),
    .rst        (rst),
    .cand_valid (cand_valid),
    .cand_idx   (cand_idx),
    .cand_score (cand_score),
    .emit_valid (emit_valid),
    .emit_idx   (emit_idx),
    .emit_score (emit_score)
  );
`else
  assign emit_valid = cand_valid;
  assign emit_idx   = cand_idx;
  assign emit_score = cand_score;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      decision_reg  <= '0;
      max_score_reg <= '0;
    end else begin
      valid_out_reg <= emit_valid;
      frame_err_reg <= err_next;
      if (emit_valid) begin
        decision_reg  <= emit_idx;
        max_score_reg <= emit_score;
      end
    end
  end

  assign valid_out = valid_out_reg;
  assign frame_err = frame_err_reg;
  assign decision  = decision_reg;
  assign max_score = max_score_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_digit_argmax.sv
// Scoreboard bench for digit_argmax: driver pushes expected events, a negedge monitor pops and compares.
module tb_digit_argmax;

  localparam int SW = 16;
  localparam int NC = 10;
  localparam int SF = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [SW-1:0] score_in = '0;
  logic                 score_valid = 1'b0;
  logic                 score_last = 1'b0;
  logic                 valid_out;
  logic [3:0]           decision;
  logic signed [SW-1:0] max_score;
  logic                 frame_err;
  logic                 busy;

  digit_argmax #(.SCORE_W(SW), .NUM_CLASSES(NC), .STABLE_FRAMES(SF)) dut (
    .clk         (clk),
    .rst         (rst),
    .score_in    (score_in),
    .score_valid (score_valid),
    .score_last  (score_last),
    .valid_out   (valid_out),
    .decision    (decision),
    .max_score   (max_score),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int idx;
    int score;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int neg_cnt = 0;
  int run = 0;
  int prev_win = 0;
  logic [3:0]           prev_dec = '0;
  logic signed [SW-1:0] prev_max = '0;

  // Monitor: pops one expected event per output pulse; otherwise outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt = neg_cnt + 1;
    if (!rst) begin
      if (valid_out || frame_err) begin
        checks = checks + 1;
        if (valid_out && frame_err) begin
          errors = errors + 1;
          $display("FAIL pulse_excl: valid_out and frame_err both high at cycle %0d", neg_cnt);
        end else if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL spurious: valid_out=%0b frame_err=%0b decision=%0d at cycle %0d, none expected",
                   valid_out, frame_err, decision, neg_cnt);
        end else begin
          e = sb.pop_front();
          if (e.is_err != frame_err || e.cyc != neg_cnt ||
              (!e.is_err && (int'(decision) != e.idx || int'(max_score) != e.score))) begin
            errors = errors + 1;
            $display("FAIL event: got err=%0b dec=%0d max=%0d cyc=%0d, want err=%0b dec=%0d max=%0d cyc=%0d",
                     frame_err, decision, max_score, neg_cnt, e.is_err, e.idx, e.score, e.cyc);
          end
        end
      end
      if (!valid_out) begin
        checks = checks + 1;
        if (decision !== prev_dec || max_score !== prev_max) begin
          errors = errors + 1;
          $display("FAIL hold: decision/max_score changed to %0d/%0d from %0d/%0d without valid_out",
                   decision, max_score, prev_dec, prev_max);
        end
      end
    end
    prev_dec = decision;
    prev_max = max_score;
  end

  task automatic push_exp(input bit is_err, input int idx, input int sc, input int cyc);
    exp_t e;
    e.is_err = is_err;
    e.idx    = idx;
    e.score  = sc;
    e.cyc    = cyc;
    sb.push_back(e);
  endtask

  // Reference for a good frame, including the optional stability gate.
  task automatic model_good(input int win, input int sc, input int cyc);
`ifdef DIGIT_ARGMAX_STABLE_EN
    if (run > 0 && win == prev_win) begin
      if (run < SF) begin
        run = run + 1;
        if (run == SF) push_exp(1'b0, win, sc, cyc);
      end
    end else begin
      run = 1;
      if (SF == 1) push_exp(1'b0, win, sc, cyc);
    end
    prev_win = win;
`else
    push_exp(1'b0, win, sc, cyc);
`endif
  endtask

  task automatic beat(input int s, input bit last, input bit busy_exp);
    checks = checks + 1;
    if (busy !== busy_exp) begin
      errors = errors + 1;
      $display("FAIL busy: got %0b want %0b at cycle %0d", busy, busy_exp, neg_cnt);
    end
    score_in    = SW'(s);
    score_valid = 1'b1;
    score_last  = last;
    @(posedge clk);
    #1;
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    score_valid = 1'b0;
    score_last  = 1'($urandom);
    score_in    = SW'($urandom);
    @(posedge clk);
    #1;
    score_last = 1'b0;
  endtask

  // Sends a whole frame; score_last rides on the final element.
  task automatic send_frame(input int sc[$]);
    int n, best, bidx;
    n = sc.size();
    best = sc[0];
    bidx = 0;
    for (int i = 1; i < NC && i < n; i++)
      if (sc[i] > best) begin
        best = sc[i];
        bidx = i;
      end
    for (int j = 0; j < n; j++) begin
      if (j == n - 1 && n < NC)  push_exp(1'b1, 0, 0, neg_cnt + 2);
      if (j == NC - 1 && n > NC) push_exp(1'b1, 0, 0, neg_cnt + 2);
      if (j == NC - 1 && n == NC) model_good(bidx, best, neg_cnt + 2);
      beat(sc[j], j == n - 1, j > 0);
    end
  endtask

  task automatic frame_with_winner(input int w);
    int sc[$];
    for (int i = 0; i < NC; i++) sc.push_back(i == w ? 100 : $urandom_range(0, 50) - 60);
    send_frame(sc);
  endtask

  task automatic check_reset_values(input string tag);
    checks = checks + 1;
    if (valid_out !== 1'b0 || frame_err !== 1'b0 || decision !== 4'd0 ||
        max_score !== '0 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL %s: valid_out=%0b frame_err=%0b decision=%0d max_score=%0d busy=%0b, want all 0",
               tag, valid_out, frame_err, decision, max_score, busy);
    end
  endtask

  initial begin
    int sc[$];
    int len, mode;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    rst = 1'b0;

    // Tie between class 2 and 4 resolves to 2.
    sc = '{5, -3, 100, 7, 100, 0, 0, 0, 0, -1};
    send_frame(sc);

    // Signed compare, winner is the very last beat.
    sc = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32767};
    send_frame(sc);

    // Short frame then a back-to-back good frame.
    sc = '{1, 2, 3, 4, 5, 6, 7};
    send_frame(sc);
    frame_with_winner(4);

    // Long frame: one error after beat 9, busy held through beat 12.
    sc = '{};
    for (int i = 0; i < 13; i++) sc.push_back(i);
    send_frame(sc);
    frame_with_winner(6);

    // Async reset in the middle of a frame.
    for (int j = 0; j < 4; j++) beat(200 + j, 1'b0, j > 0);
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    run = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame_with_winner(7);

    // Stability sequence; in the default build every frame emits.
    frame_with_winner(3);
    frame_with_winner(3);
    frame_with_winner(5);
    frame_with_winner(5);
    frame_with_winner(5);
    frame_with_winner(5);
    frame_with_winner(3);

    // Randomized frames with occasional bad lengths, ties and idle gaps.
    for (int f = 0; f < 150; f++) begin
      mode = $urandom_range(0, 7);
      len = (mode == 0) ? $urandom_range(1, NC - 1) :
            (mode == 1) ? $urandom_range(NC + 1, NC + 4) : NC;
      sc = '{};
      for (int i = 0; i < len; i++)
        sc.push_back(f[0] ? $urandom_range(0, 6) - 3 : $urandom_range(0, 65535) - 32768);
      send_frame(sc);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    repeat (4) idle_cycle();
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expected events never observed, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
